instr_fetch: RTL and testbench

- Fetch stage directly upstream of the decode/control unit.
- Owns the PC and runs a req/ack handshake to instruction memory.
- Registers the fetched word and presents it with a valid flag.
- Splits out the opcode, funct3 and funct7 fields consumed by control decode, and applies branch redirects.

---
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, runs the imem req/ack handshake and presents one registered instruction.
// Optional misaligned-branch fault state and sticky fetch_fault port: define INSTR_FETCH_MISALIGN_CHECK_EN.
module instr_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_fault
`endif
);

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    ,
    S_FAULT = 2'd3
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            imem_req_q, imem_req_d;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  logic            fetch_fault_q, fetch_fault_d;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
      fetch_fault_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
      fetch_fault_q <= fetch_fault_d;
`endif
    end
  end

  // Next-state logic; branch inputs matter only on the consume edge
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    fetch_fault_d = fetch_fault_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
          if (branch_taken) begin
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
            pc_d = branch_target;
            if (branch_target[1:0] != 2'b00) begin
              state_d       = S_FAULT;
              fetch_fault_d = 1'b1;
            end
`else
            pc_d = branch_target & ALIGN_MSK;
`endif
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase
    // Request is a registered decode of the state being entered
    imem_req_d = (state_d == S_REQ);
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[31:25];
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = fetch_fault_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table of fetch/stall/consume records, a memory responder,
// and a scoreboard of fetched words; hand sequences for reset-mid-request and misaligned branch.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7)
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  typedef struct {
    int          waits;
    int          stalls;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] exp_next;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  vec_t        vecs[8];
  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 8 && imem_req !== 1'b1; i++) @(negedge clk);
    chk("req_timeout", 32'(imem_req), 32'd1);
  endtask

  // One instruction: request with waits, scoreboard check, stall window, consume
  task automatic do_instr(input vec_t v, input bit chk_next);
    exp_t e;
    wait_req();
    for (int w = 0; w <= v.waits; w++) begin
      if (w > 0) @(negedge clk);
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, exp_pc);
      chk("valid_low_in_req", 32'(instr_valid), 32'd0);
      if (w == v.waits) begin
        imem_ack     = 1'b1;
        imem_rdata   = mem_word(exp_pc);
        branch_taken = 1'b0;
        sb.push_back('{exp_pc, mem_word(exp_pc)});
      end else begin
        imem_ack      = 1'b0;
        imem_rdata    = 32'hDEAD_BEEF;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
      end
    end
    @(negedge clk);
    imem_ack     = 1'b0;
    imem_rdata   = 32'hDEAD_BEEF;
    branch_taken = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("valid_rise", 32'(instr_valid), 32'd1);
    chk("instr", instr, e.word);
    chk("pc", pc, e.pc);
    chk("opcode", 32'(opcode), 32'(e.word[6:0]));
    chk("funct3", 32'(funct3), 32'(e.word[14:12]));
    chk("funct7", 32'(funct7), 32'(e.word[31:25]));
    chk("req_low_valid", 32'(imem_req), 32'd0);
    if (v.stalls > 0) begin
      stall         = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0300;
    end
    for (int s = 0; s < v.stalls; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, e.word);
      chk("stall_pc", pc, e.pc);
      chk("stall_no_req", 32'(imem_req), 32'd0);
    end
    stall         = 1'b0;
    branch_taken  = v.br;
    branch_target = v.tgt;
    @(negedge clk);
    branch_taken  = 1'b0;
    if (chk_next) begin
      chk("consume_valid_low", 32'(instr_valid), 32'd0);
      chk("next_req", 32'(imem_req), 32'd1);
      chk("next_addr", imem_addr, v.exp_next);
    end
    exp_pc = v.exp_next;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t mis;
    vecs[0] = '{0, 0, 1'b0, 32'h0,         32'h0000_0004};
    vecs[1] = '{3, 0, 1'b0, 32'h0,         32'h0000_0008};
    vecs[2] = '{0, 5, 1'b0, 32'h0,         32'h0000_000C};
    vecs[3] = '{1, 2, 1'b0, 32'h0,         32'h0000_0010};
    vecs[4] = '{0, 0, 1'b1, 32'h0000_0040, 32'h0000_0040};
    vecs[5] = '{2, 0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[6] = '{0, 1, 1'b0, 32'h0,         32'h0000_0000};
    vecs[7] = '{0, 0, 1'b1, 32'h0000_0020, 32'h0000_0020};

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    exp_pc = RESET_PC;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_opcode", 32'(opcode), 32'h13);
    chk("rst_funct3", 32'(funct3), 32'h0);
    chk("rst_funct7", 32'(funct7), 32'h0);
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    chk("rst_fault", 32'(fetch_fault), 32'd0);
`endif
    rst_n = 1'b1;
    #1 chk("idle_no_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);

    for (int i = 0; i < 8; i++) do_instr(vecs[i], 1'b1);

    // Reset while requesting 0x20: req drops at once; a late ack after release is ignored
    wait_req();
    chk("pre_rst_addr", imem_addr, 32'h0000_0020);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", pc, RESET_PC);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, RESET_PC);
    chk("late_ack_ignored", 32'(instr_valid), 32'd0);
    exp_pc = RESET_PC;

    // Misaligned branch target 0x42
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    mis = '{0, 0, 1'b1, 32'h0000_0042, 32'h0000_0042};
    do_instr(mis, 1'b0);
    chk("fault_set", 32'(fetch_fault), 32'd1);
    chk("fault_pc", pc, 32'h0000_0042);
    chk("fault_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1;
      @(negedge clk);
      chk("fault_sticky", 32'(fetch_fault), 32'd1);
      chk("fault_no_req", 32'(imem_req), 32'd0);
      chk("fault_no_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b0;
`else
    mis = '{0, 0, 1'b1, 32'h0000_0042, 32'h0000_0040};
    do_instr(mis, 1'b1);
    mis = '{1, 0, 1'b0, 32'h0, 32'h0000_0044};
    do_instr(mis, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
